// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract sequencer built on one shared 4-bit adder slice.
// Nibbles are processed LSB first, one per clock, with the carry held in a register.
module nibble_serial_adder_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int unsigned MSB     = WIDTH - 1;

  generate
    if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
      $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic             w_accept;
  logic             w_run;
  logic             w_last;
  logic             w_in_ready_nxt;
  logic             w_out_valid_nxt;
  logic             w_busy_nxt;
  logic [IDX_W+1:0] w_base;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [4:0]       w_slice;

  // Shared 4-bit slice; operand B is already inverted for subtraction.
  assign w_base  = {r_idx, 2'b00};
  assign w_a_nib = r_a[w_base +: 4];
  assign w_b_nib = r_b[w_base +: 4];
  assign w_slice = 5'(w_a_nib) + 5'(w_b_nib) + 5'(r_carry);
  assign w_last  = (r_idx == IDX_W'(NIBBLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Next state; handshake outputs are registered from the next state.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_run       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_run = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_in_ready_nxt  = (w_state_nxt == S_IDLE);
    w_out_valid_nxt = (w_state_nxt == S_DONE);
    w_busy_nxt      = (w_state_nxt == S_RUN) || (w_state_nxt == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a     <= op_a;
      r_b     <= sub ? ~op_b : op_b;
      r_carry <= sub ? 1'b1 : cin;
      r_idx   <= '0;
    end else if (w_run) begin
      r_result[w_base +: 4] <= w_slice[3:0];
      r_carry               <= w_slice[4];
      r_idx                 <= w_last ? '0 : r_idx + IDX_W'(1);
      if (w_last) begin
        r_cout <= w_slice[4];
        r_ovf  <= (r_a[MSB] == r_b[MSB]) && (w_slice[3] != r_a[MSB]);
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign result    = r_result;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl at WIDTH=16 with hand-computed results.
module tb_nibble_serial_adder_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        cout;
  logic        ovf;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic s);
    op_a     = a;
    op_b     = b;
    cin      = c;
    sub      = s;
    in_valid = 1'b1;
  endtask

  // Counts edges after the accept edge until out_valid rises (bounded).
  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd4);
  endtask

  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic s, input logic [15:0] e_res,
                       input logic e_cout, input logic e_ovf);
    int lat;
    present(a, b, c, s);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(tag, lat);
    chk({tag, "_result"}, 32'(result), 32'(e_res));
    chk({tag, "_cout"}, 32'(cout), 32'(e_cout));
    chk({tag, "_ovf"}, 32'(ovf), 32'(e_ovf));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_ov_clr"}, 32'(out_valid), 32'd0);
    chk({tag, "_ir_back"}, 32'(in_ready), 32'd1);
  endtask

  logic [15:0] b2b_a   [3] = '{16'h0F0F, 16'h8000, 16'hFFFF};
  logic [15:0] b2b_b   [3] = '{16'h0101, 16'h0001, 16'h0001};
  logic        b2b_s   [3] = '{1'b0, 1'b1, 1'b0};
  logic [15:0] b2b_res [3] = '{16'h1010, 16'h7FFF, 16'h0000};
  logic        b2b_co  [3] = '{1'b0, 1'b1, 1'b1};
  logic        b2b_ov  [3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    int lat;
    int t;
    int n_acc;
    int n_res;
    int acc_t [3];
    logic [15:0] held;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    rst_n = 1'b1;
    step();

    do_op("add1", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
    do_op("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    do_op("sub_borrow", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op("add_cin_ovf", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("sub_ign_cin", 16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Consumer stalls in DONE while a new request waits.
    present(16'h00A0, 16'h0005, 1'b0, 1'b0);
    step();
    wait_done("stall", lat);
    held = result;
    chk("stall_first", 32'(held), 32'h00A5);
    present(16'h1000, 16'h2000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_ov", 32'(out_valid), 32'd1);
      chk("stall_res", 32'(result), 32'(held));
      chk("stall_ir", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("stall_ir_hs", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("stall_accepted", 32'(busy), 32'd1);
    wait_done("stall_next", lat);
    chk("stall_next_res", 32'(result), 32'h3000);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset during the second RUN cycle aborts the operation.
    present(16'h1234, 16'h1111, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("arst_result", 32'(result), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_cout_ovf", 32'({cout, ovf}), 32'd0);
    #2;
    rst_n = 1'b1;
    step();
    do_op("after_rst", 16'h4321, 16'h0102, 1'b1, 1'b0, 16'h4424, 1'b0, 1'b0);

    // Back-to-back ops with in_valid and out_ready held high.
    n_acc = 0;
    n_res = 0;
    out_ready = 1'b1;
    present(b2b_a[0], b2b_b[0], 1'b0, b2b_s[0]);
    t = 0;
    while (n_res < 3 && t < 60) begin
      logic acc_now;
      acc_now = in_valid && in_ready;
      if (acc_now) begin
        acc_t[n_acc] = t;
        n_acc++;
      end
      if (out_valid && out_ready) begin
        chk("b2b_res", 32'(result), 32'(b2b_res[n_res]));
        chk("b2b_cout", 32'(cout), 32'(b2b_co[n_res]));
        chk("b2b_ovf", 32'(ovf), 32'(b2b_ov[n_res]));
        n_res++;
        if (n_acc < 3) present(b2b_a[n_acc], b2b_b[n_acc], 1'b0, b2b_s[n_acc]);
        else in_valid = 1'b0;
      end
      step();
      t++;
      if (acc_now) op_a = 16'hDEAD;
    end
    chk("b2b_count", 32'(n_res), 32'd3);
    if (n_acc == 3) begin
      chk("b2b_gap1", 32'(acc_t[1] - acc_t[0]), 32'd6);
      chk("b2b_gap2", 32'(acc_t[2] - acc_t[1]), 32'd6);
    end else begin
      chk("b2b_accepts", 32'(n_acc), 32'd3);
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
